// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and types for the multi-port register file
//                and its busy-bit scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Index of the hardwired-zero register.
    localparam int REG_ZERO       = 0;

    // Default geometry of the NPC general-purpose register file.
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register busy bits. Allocation sets a bit, any enabled
//                write to the register clears it, allocation wins over a
//                same-cycle write. Register 0 is never busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NR_WR      = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NR_WR-1:0]            wen_i,
    input  logic [NR_WR*ADDR_WIDTH-1:0] waddr_i,
    input  logic                        alloc_en_i,
    input  logic [ADDR_WIDTH-1:0]       alloc_addr_i,
    output logic [2**ADDR_WIDTH-1:0]    busy_o,
    output logic                        busy_any_o
);

    localparam int                    DEPTH       = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next-state: hold, then clear on writes, then set on allocation (highest priority).
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NR_WR; j++) begin
            if (wen_i[j] && (waddr_i[j*ADDR_WIDTH +: ADDR_WIDTH] != C_ZERO_ADDR)) begin
                busy_d[waddr_i[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (alloc_en_i && (alloc_addr_i != C_ZERO_ADDR)) begin
            busy_d[alloc_addr_i] = 1'b1;
        end
    end

    // Busy vector register; reset clears every pending flag and discards this cycle's updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_any_o = |busy_q;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-port register file (NR_RD combinational reads, NR_WR
//                synchronous writes, r0 hardwired to zero) with an integrated
//                busy-bit scoreboard for RAW hazard detection.
//                Optional macro REGFILE_BYPASS_EN forwards same-cycle write
//                data to matching read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NR_RD      = 2,
    parameter int NR_WR      = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NR_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NR_RD*DATA_WIDTH-1:0] rdata,
    output logic [NR_RD-1:0]            rbusy,
    input  logic [NR_WR-1:0]            wen,
    input  logic [NR_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NR_WR*DATA_WIDTH-1:0] wdata,
    input  logic                        alloc_en,
    input  logic [ADDR_WIDTH-1:0]       alloc_addr,
    output logic                        busy_any
);

    localparam int                    DEPTH       = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [ADDR_WIDTH-1:0] rd_idx;

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NR_WR      (NR_WR)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .wen_i        (wen),
        .waddr_i      (waddr),
        .alloc_en_i   (alloc_en),
        .alloc_addr_i (alloc_addr),
        .busy_o       (busy),
        .busy_any_o   (busy_any)
    );

    // Data array: reset zeroes everything; later write ports override earlier ones; r0 never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NR_WR; j++) begin
                if (wen[j] && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] != C_ZERO_ADDR)) begin
                    rf_q[waddr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Read muxes (r0 reads zero because it is never written and never busy), plus optional forwarding.
    always_comb begin
        rdata  = '0;
        rbusy  = '0;
        rd_idx = '0;
        for (int k = 0; k < NR_RD; k++) begin
            rd_idx = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
            rdata[k*DATA_WIDTH +: DATA_WIDTH] = rf_q[rd_idx];
            rbusy[k] = busy[rd_idx];
`ifdef REGFILE_BYPASS_EN
            // Highest matching write port is visited last, so it wins.
            for (int j = 0; j < NR_WR; j++) begin
                if (wen[j] && (rd_idx != C_ZERO_ADDR)
                    && (waddr[j*ADDR_WIDTH +: ADDR_WIDTH] == rd_idx)) begin
                    rdata[k*DATA_WIDTH +: DATA_WIDTH] = wdata[j*DATA_WIDTH +: DATA_WIDTH];
                    // The forwarded value is final unless a newer producer is issued now.
                    rbusy[k] = alloc_en && (alloc_addr == rd_idx);
                end
            end
`endif
        end
    end

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp (2 read, 2 write ports).
//                A reference model of the architectural state is checked on
//                every negative edge, with directed literal checks on top.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rbusy;
    logic [NW-1:0]    wen;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic             alloc_en;
    logic [AW-1:0]    alloc_addr;
    logic             busy_any;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [DW-1:0] m_rf   [32];
    bit            m_busy [32];

    regfile_mp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NR_RD      (NR),
        .NR_WR      (NW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy_any   (busy_any)
    );

    always #5 clk = ~clk;

    // Architectural model: state change at each rising edge from the spec's rules.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_rf[i]   = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (wen[j] && waddr[j*AW +: AW] != 0) begin
                    m_rf[waddr[j*AW +: AW]]   = wdata[j*DW +: DW];
                    m_busy[waddr[j*AW +: AW]] = 1'b0;
                end
            end
            if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
    end

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = (a == 0) ? '0 : m_rf[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NW; j++)
            if (wen[j] && a != 0 && waddr[j*AW +: AW] == a) v = wdata[j*DW +: DW];
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic b;
        b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NW; j++)
            if (wen[j] && a != 0 && waddr[j*AW +: AW] == a) b = alloc_en && (alloc_addr == a);
`endif
        return b;
    endfunction

    function automatic logic exp_any();
        logic r = 1'b0;
        for (int i = 0; i < 32; i++) r = r | m_busy[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Continuous comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NR; k++) begin
                check($sformatf("model rdata%0d a=%0d", k, raddr[k*AW +: AW]),
                      rdata[k*DW +: DW], exp_data(raddr[k*AW +: AW]));
                check($sformatf("model rbusy%0d a=%0d", k, raddr[k*AW +: AW]),
                      {31'd0, rbusy[k]}, {31'd0, exp_busy(raddr[k*AW +: AW])});
            end
            check("model busy_any", {31'd0, busy_any}, {31'd0, exp_any()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen      = '0;
        alloc_en = 1'b0;
    endtask

    task automatic wr(input int port, input int a, input logic [DW-1:0] d);
        wen[port]            = 1'b1;
        waddr[port*AW +: AW] = AW'(a);
        wdata[port*DW +: DW] = d;
    endtask

    task automatic rd(input int a0, input int a1);
        raddr[0 +: AW]  = AW'(a0);
        raddr[AW +: AW] = AW'(a1);
    endtask

    initial begin
        rst = 1'b1; raddr = '0; wen = '0; waddr = '0; wdata = '0;
        alloc_en = 1'b0; alloc_addr = '0;
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state on every address, both ports.
        for (int a = 0; a < 32; a++) begin
            rd(a, 31 - a);
            @(negedge clk);
            check("reset rdata0", rdata[0 +: DW], 32'h0);
            check("reset rdata1", rdata[DW +: DW], 32'h0);
            check("reset rbusy", {30'd0, rbusy}, 32'h0);
            check("reset busy_any", {31'd0, busy_any}, 32'h0);
            step();
        end

        // Basic write, then write to r0 dropped.
        wr(0, 5, 32'hDEADBEEF); step(); idle();
        rd(5, 0); @(negedge clk);
        check("wr5 rdata0", rdata[0 +: DW], 32'hDEADBEEF);
        wr(0, 0, 32'h1234); step(); idle();
        rd(0, 5); @(negedge clk);
        check("r0 rdata0", rdata[0 +: DW], 32'h0);
        check("r0 rbusy0", {31'd0, rbusy[0]}, 32'h0);
        step();

        // Both ports to address 7: port 1 wins, busy cleared.
        alloc_en = 1'b1; alloc_addr = 7; step(); idle();
        wr(0, 7, 32'h11); wr(1, 7, 32'h22); step(); idle();
        rd(7, 7); @(negedge clk);
        check("dual wr7 data", rdata[0 +: DW], 32'h22);
        check("dual wr7 busy", {31'd0, rbusy[0]}, 32'h0);
        step();

        // Scoreboard: alloc, clear by write, alloc+write same cycle, re-alloc.
        alloc_en = 1'b1; alloc_addr = 3; step(); idle();
        rd(3, 0); @(negedge clk);
        check("alloc3 rbusy", {31'd0, rbusy[0]}, 32'h1);
        check("alloc3 busy_any", {31'd0, busy_any}, 32'h1);
        step();
        wr(0, 3, 32'h55); step(); idle();
        @(negedge clk);
        check("wr3 rbusy", {31'd0, rbusy[0]}, 32'h0);
        check("wr3 rdata", rdata[0 +: DW], 32'h55);
        check("wr3 busy_any", {31'd0, busy_any}, 32'h0);
        step();
        wr(1, 3, 32'h66); alloc_en = 1'b1; alloc_addr = 3; step(); idle();
        @(negedge clk);
        check("alloc+wr3 rbusy", {31'd0, rbusy[0]}, 32'h1);
        check("alloc+wr3 rdata", rdata[0 +: DW], 32'h66);
        step();
        alloc_en = 1'b1; alloc_addr = 3; step(); idle();
        @(negedge clk);
        check("realloc3 rbusy", {31'd0, rbusy[0]}, 32'h1);
        step();
        wr(0, 3, 32'h77); step(); idle();

        // Same-cycle read of a register being written.
        rd(0, 9); wr(0, 9, 32'hCAFE);
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        check("bypass rdata1", rdata[DW +: DW], 32'hCAFE);
`else
        check("no-bypass rdata1", rdata[DW +: DW], 32'h0);
`endif
        check("same-cycle rbusy1", {31'd0, rbusy[1]}, 32'h0);
        step(); idle();
        @(negedge clk);
        check("wr9 settled", rdata[DW +: DW], 32'hCAFE);
        step();

        // Fill r1..r31 with their index, two per cycle.
        for (int a = 1; a < 32; a += 2) begin
            idle();
            wr(0, a, DW'(a));
            if (a + 1 < 32) wr(1, a + 1, DW'(a + 1));
            step();
        end
        idle();
        alloc_en = 1'b1; alloc_addr = 4; step(); idle();
        rd(31, 4); @(negedge clk);
        check("fill r31", rdata[0 +: DW], 32'd31);
        check("fill r4 busy", {31'd0, rbusy[1]}, 32'h1);
        step();

        // Reset mid-operation with a write and alloc in the same cycle.
        rst = 1'b1; wr(0, 10, 32'hFFFF); alloc_en = 1'b1; alloc_addr = 6;
        step();
        rst = 1'b0; idle();
        for (int a = 0; a < 32; a++) begin
            rd(a, 31 - a);
            @(negedge clk);
            check("post-rst rdata0", rdata[0 +: DW], 32'h0);
            check("post-rst rdata1", rdata[DW +: DW], 32'h0);
            check("post-rst busy_any", {31'd0, busy_any}, 32'h0);
            step();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_regfile_mp
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Multi-port, parametrised general-purpose register file for the NPC core, with an integrated busy-bit scoreboard.
- Supports N combinational read ports and M synchronous write ports; register 0 is hardwired to zero.
- Per-register pending flags let the issue stage detect read-after-write hazards.
- Sits between decode/issue (reads, allocation) and writeback (writes); successor to the single-write, two-read file.

Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register width in bits.
- NR_RD, 2, number of read ports (1..4).
- NR_WR, 1, number of write ports (1..2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- raddr  in  NR_RD*ADDR_WIDTH  read addresses; port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NR_RD*DATA_WIDTH  read data, combinational.
- rbusy  out  NR_RD  pending flag of each read address, combinational.
- wen  in  NR_WR  write enables.
- waddr  in  NR_WR*ADDR_WIDTH  write addresses.
- wdata  in  NR_WR*DATA_WIDTH  write data.
- alloc_en  in  1  mark alloc_addr pending (destination issued).
- alloc_addr  in  ADDR_WIDTH  register being allocated.
- busy_any  out  1  OR of all busy bits (used for pipeline drain / ebreak).

Behaviour:
- Reset (rst=1 at posedge): all registers are set to 0 and all busy bits cleared. Registered outputs have no separate reset; after reset rdata=0, rbusy=0 and busy_any=0 for every address.
- Reads: rdata[k] = rf[raddr[k]] with zero latency. raddr=0 always returns 0 and rbusy=0.
- Writes take effect at posedge when wen[j]=1 and waddr[j]!=0. Writes to address 0 are dropped and never change busy state.
- Multiple write ports targeting the same address in one cycle: the highest-index port wins, for both data and busy clear.
- Scoreboard: each register has one busy bit with the following per-cycle update, in priority order:
  - set when alloc_en=1 and alloc_addr matches (alloc_addr!=0);
  - else cleared when any enabled write port targets that register;
  - else held.
- Alloc and write to the same address in the same cycle: the data is written and the bit stays set, because the newer producer is pending.
- alloc_en to an already-busy register: no error; the bit stays set.
- busy_any is combinational from the busy bits registered at the previous edge.
- rst asserted mid-operation: pending writes in that cycle are discarded and the scoreboard is cleared. rst has priority over wen and alloc_en.
- No X propagation: the register array is fully initialised by reset; simulation before the first reset is undefined.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- When defined: a read whose address matches a same-cycle enabled write (nonzero address) returns that write's wdata (highest matching port wins), and rbusy for that port is forced to 0 unless alloc_en targets the same address that cycle.
- When undefined: reads return the pre-edge array value and rbusy reflects the stored busy bit only. Forwarding is then the pipeline's responsibility.

Decomposition:
- Package regfile_pkg holds:
  - localparam REG_ZERO = 0;
  - default ADDR_WIDTH and DATA_WIDTH;
  - typedef reg_idx_t (logic [ADDR_WIDTH-1:0]) and typedef reg_data_t.
- One sub-module, regfile_scoreboard: the busy-bit vector with set/clear priority logic and busy_any. It takes the wen/waddr vectors and the alloc signals, and outputs the busy vector.
- The data array, the read muxes and the optional bypass stay in regfile_mp.

Test Plan:
- Reset then read all 32 addresses on both ports -> rdata=0x0, rbusy=0, busy_any=0.
- wen[0]=1, waddr=5, wdata=0xDEADBEEF; next cycle raddr0=5 -> rdata0=0xDEADBEEF. Write waddr=0, wdata=0x1234 -> raddr=0 still reads 0.
- NR_WR=2, both ports write addr 7 (0x11, 0x22) in the same cycle -> rdata for 7 = 0x22; busy bit of 7 cleared.
- alloc_en addr 3 -> next cycle rbusy=1, busy_any=1. Write addr 3 = 0x55 -> next cycle rbusy=0, rdata=0x55. Alloc and write to 3 in the same cycle -> busy stays 1.
- With REGFILE_BYPASS_EN, write addr 9 = 0xCAFE while raddr1=9 in the same cycle -> rdata1=0xCAFE combinationally. Without the macro -> old value 0.
- Fill regs 1..31 with their index, alloc 4, assert rst for one cycle -> all reads 0, busy_any=0; the write issued in the reset cycle is not retained.
